vga_timing_gen: RTL and testbench

Generates raster scan timing for the 640x480 @ 60 Hz VGA path. Produces pixel coordinates x/y, the visible-area flag frame_active and the active-low sync pulses. x, y and frame_active drive the overlay/text/sine layers directly, and the syncs go to the output pins. Also supplies a per-frame tick and a free-running frame counter, which the animated layers use as a time base.

---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing for a VGA path: x/y position, registered syncs,
//            visible-area flag, per-frame tick and frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_active,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int         c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_active;
    logic              r_frame_tick;
    logic [FCNT_W-1:0] r_frame_count;

    logic [9:0]        w_x_next;
    logic [9:0]        w_y_next;
    logic              w_x_end;
    logic              w_y_end;
    logic              w_wrap;

    always_comb begin
        w_x_end  = (r_x == c_H_LAST);
        w_y_end  = (r_y == c_V_LAST);
        w_wrap   = ce & w_x_end & w_y_end;
        w_x_next = r_x;
        w_y_next = r_y;
        if (ce) begin
            if (w_x_end) begin
                w_x_next = '0;
                w_y_next = w_y_end ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Decodes are taken from the next position so they line up with x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x            <= '0;
            r_y            <= '0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_frame_active <= 1'b1;
            r_frame_tick   <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_x            <= w_x_next;
            r_y            <= w_y_next;
            r_hsync        <= !((w_x_next >= c_HS_START) && (w_x_next < c_HS_END));
            r_vsync        <= !((w_y_next >= c_VS_START) && (w_y_next < c_VS_END));
            r_frame_active <= (w_x_next < c_H_VIS) && (w_y_next < c_V_VIS);
            r_frame_tick   <= w_wrap;
            if (w_wrap) begin
                r_frame_count <= r_frame_count + FCNT_W'(1);
            end
        end
    end

    assign x            = r_x;
    assign y            = r_y;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign frame_active = r_frame_active;
    assign frame_tick   = r_frame_tick;
    assign frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Checks a full-size and a shrunken timing generator against an
//            arithmetic model derived from the enabled-edge count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int c_SHV = 8, c_SHF = 2, c_SHS = 3, c_SHB = 2;
    localparam int c_SVV = 6, c_SVF = 1, c_SVS = 2, c_SVB = 1;
    localparam int c_S_FRAME = (c_SHV + c_SHF + c_SHS + c_SHB) * (c_SVV + c_SVF + c_SVS + c_SVB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_fa, d_tick, s_hs, s_vs, s_fa, s_tick;
    logic [7:0] d_cnt, s_cnt;

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .ce(ce), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
        .frame_active(d_fa), .frame_tick(d_tick), .frame_count(d_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(c_SHV), .H_FRONT(c_SHF), .H_SYNC(c_SHS), .H_BACK(c_SHB),
        .V_VISIBLE(c_SVV), .V_FRONT(c_SVF), .V_SYNC(c_SVS), .V_BACK(c_SVB), .FCNT_W(8)
    ) u_small (
        .clk(clk), .rst(rst), .ce(ce), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
        .frame_active(s_fa), .frame_tick(s_tick), .frame_count(s_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Position is the enabled-edge count modulo the frame length.
    function automatic logic [31:0] model_vec(input int n, input bit le,
        input int hv, input int hf, input int hs, input int hb,
        input int vv, input int vf, input int vs, input int vb);
        int ht  = hv + hf + hs + hb;
        int vt  = vv + vf + vs + vb;
        int fl  = ht * vt;
        int pos = n % fl;
        int px  = pos % ht;
        int py  = pos / ht;
        logic [31:0] v;
        v[31:22] = 10'(px);
        v[21:12] = 10'(py);
        v[11]    = !((px >= hv + hf) && (px < hv + hf + hs));
        v[10]    = !((py >= vv + vf) && (py < vv + vf + vs));
        v[9]     = (px < hv) && (py < vv);
        v[8]     = le && (pos == 0) && (n > 0);
        v[7:0]   = 8'(n / fl);
        return v;
    endfunction

    int d_n = 0, s_n = 0;
    bit le  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_n = 0; s_n = 0; le = 1'b0;
        end else begin
            le = ce;
            if (ce) begin
                d_n++; s_n++;
            end
        end
    end

    int  phase = 0;
    int  cyc = 0;
    int  hrun = 0, s_act = 0, s_vlow = 0;
    int  last_tick_cyc = -1;
    bit  wrap_seen = 1'b0;
    logic [7:0] prev_s_cnt = 8'd0;

    always @(negedge clk) begin
        cyc++;
        check("full", {d_x, d_y, d_hs, d_vs, d_fa, d_tick, d_cnt},
              model_vec(d_n, le, 640, 16, 96, 48, 480, 10, 2, 33));
        check("small", {s_x, s_y, s_hs, s_vs, s_fa, s_tick, s_cnt},
              model_vec(s_n, le, c_SHV, c_SHF, c_SHS, c_SHB, c_SVV, c_SVF, c_SVS, c_SVB));
        if (phase == 1) begin
            if (d_n < 800 && !d_hs) hrun++;
            if (d_n == 799) check("hsync_run", 32'(hrun), 32'd96);
            if (d_n == 800) check("line_wrap", {d_x, d_y}, {10'd0, 10'd1});
            if (d_n == 639) check("fa_x639", 32'(d_fa), 32'd1);
            if (d_n == 640) check("fa_x640", 32'(d_fa), 32'd0);
            if (d_n == 655) check("hs_x655", 32'(d_hs), 32'd1);
            if (d_n == 656) check("hs_x656", 32'(d_hs), 32'd0);
            if (d_n == 752) check("hs_x752", 32'(d_hs), 32'd1);
            if (s_n < c_S_FRAME) begin
                if (s_fa) s_act++;
                if (!s_vs) s_vlow++;
            end
            if (s_n == 5 * 15) check("fa_ylast", 32'(s_fa), 32'd1);
            if (s_n == 6 * 15) check("fa_yvis", 32'(s_fa), 32'd0);
            if (s_n == c_S_FRAME) begin
                check("active_cnt", 32'(s_act), 32'(c_SHV * c_SVV));
                check("vsync_cnt", 32'(s_vlow), 32'(c_SVS * 15));
                check("tick_f1", {s_tick, s_cnt}, {1'b1, 8'd1});
            end
        end
        if (phase == 2 && s_tick) begin
            if (last_tick_cyc >= 0) check("ce_half_frame", 32'(cyc - last_tick_cyc), 32'(2 * c_S_FRAME));
            last_tick_cyc = cyc;
        end
        if (phase == 3 && s_tick && s_cnt == 8'd0 && prev_s_cnt == 8'd255) wrap_seen = 1'b1;
        prev_s_cnt = s_cnt;
    end

    localparam logic [31:0] c_RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check("rst_full", {d_x, d_y, d_hs, d_vs, d_fa, d_tick, d_cnt}, c_RST_VEC);
        check("rst_small", {s_x, s_y, s_hs, s_vs, s_fa, s_tick, s_cnt}, c_RST_VEC);
        rst = 1'b0;
        ce  = 1'b1;
        phase = 1;
        repeat (1700) @(negedge clk);
        phase = 0;

        guard = 0;
        while (d_x != 10'd300 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("wait_x300", 32'(d_x), 32'd300);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_full", {d_x, d_y, d_hs, d_vs, d_fa, d_tick, d_cnt}, c_RST_VEC);
        check("async_small", {s_x, s_y, s_hs, s_vs, s_fa, s_tick, s_cnt}, c_RST_VEC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("resume", {d_x, d_y}, {10'd1, 10'd0});

        phase = 2;
        for (int i = 0; i < 700; i++) begin
            ce = ~ce;
            @(negedge clk);
        end

        phase = 3;
        guard = 0;
        while (s_n < 257 * c_S_FRAME && guard < 60000) begin
            ce = ($urandom_range(3) != 0);
            @(negedge clk);
            guard++;
        end
        if (guard >= 60000) check("phase3_timeout", 32'(s_n), 32'(257 * c_S_FRAME));
        check("count_wrap", 32'(wrap_seen), 32'd1);
        phase = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
